// File: rtl/sprite_motion_ctrl.sv
// Sprite motion controller: samples the gamepad once per frame (at the last
// visible pixel) and moves the sprite with a speed that ramps while held.
// Optional macro SPRITE_WRAP_EN: screen edges wrap instead of clamping.
module sprite_motion_ctrl #(
  parameter int unsigned SCREEN_W     = 640,
  parameter int unsigned SCREEN_H     = 480,
  parameter int unsigned SPRITE_W     = 14,
  parameter int unsigned SPRITE_H     = 14,
  parameter int unsigned INIT_X       = 313,
  parameter int unsigned INIT_Y       = 233,
  parameter int unsigned MAX_SPEED    = 4,
  parameter int unsigned ACCEL_FRAMES = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [9:0] x,
  input  logic [8:0] y,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [9:0] sprite_x,
  output logic [8:0] sprite_y,
  output logic       frame_tick,
  output logic       moving
);

  localparam int unsigned AW    = 11;
  localparam int unsigned SPD_W = 4;
  localparam int unsigned CNT_W = 8;

  localparam logic [9:0]    X_LAST = 10'(SCREEN_W - 1);
  localparam logic [8:0]    Y_LAST = 9'(SCREEN_H - 1);
  localparam logic [AW-1:0] X_MAX  = AW'(SCREEN_W - SPRITE_W);
  localparam logic [AW-1:0] Y_MAX  = AW'(SCREEN_H - SPRITE_H);
`ifdef SPRITE_WRAP_EN
  localparam logic [AW-1:0] X_MOD  = AW'(SCREEN_W - SPRITE_W + 1);
  localparam logic [AW-1:0] Y_MOD  = AW'(SCREEN_H - SPRITE_H + 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RAMP   = 2'd1,
    S_CRUISE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [SPD_W-1:0]  speed, speed_nxt, speed_inc, step;
  logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
  logic [3:0]        btn_meta, btn_sync;
  logic              match, match_d, event_c;
  logic              dir_up, dir_down, dir_left, dir_right, any_dir;
  logic [AW-1:0]     px, py, st, sum_x, sum_y;
  logic [9:0]        x_nxt;
  logic [8:0]        y_nxt;

  // Frame event: first cycle the scan sits on the last visible pixel
  assign match   = (x == X_LAST) && (y == Y_LAST);
  assign event_c = match && !match_d;

  // Effective directions; opposing buttons on one axis cancel
  assign dir_up    = btn_sync[3] & ~btn_sync[2];
  assign dir_down  = btn_sync[2] & ~btn_sync[3];
  assign dir_left  = btn_sync[1] & ~btn_sync[0];
  assign dir_right = btn_sync[0] & ~btn_sync[1];
  assign any_dir   = dir_up | dir_down | dir_left | dir_right;

  assign speed_inc = speed + SPD_W'(1);
  assign cnt_inc   = cnt + CNT_W'(1);

  // Next state, speed ramp and next position for the coming event
  always_comb begin
    state_nxt = state;
    speed_nxt = speed;
    cnt_nxt   = cnt;
    step      = speed;
    x_nxt     = sprite_x;
    y_nxt     = sprite_y;
    px        = AW'(sprite_x);
    py        = AW'(sprite_y);
    st        = '0;
    sum_x     = '0;
    sum_y     = '0;

    case (state)
      S_IDLE: begin
        step      = SPD_W'(1);
        speed_nxt = SPD_W'(1);
        cnt_nxt   = '0;
        if (any_dir) state_nxt = (MAX_SPEED <= 1) ? S_CRUISE : S_RAMP;
      end
      S_RAMP: begin
        if (!any_dir) begin
          state_nxt = S_IDLE;
          speed_nxt = SPD_W'(1);
          cnt_nxt   = '0;
        end else if (cnt_inc == CNT_W'(ACCEL_FRAMES)) begin
          cnt_nxt   = '0;
          speed_nxt = speed_inc;
          if (speed_inc == SPD_W'(MAX_SPEED)) state_nxt = S_CRUISE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      S_CRUISE: begin
        step = SPD_W'(MAX_SPEED);
        if (!any_dir) begin
          state_nxt = S_IDLE;
          speed_nxt = SPD_W'(1);
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        speed_nxt = SPD_W'(1);
        cnt_nxt   = '0;
      end
    endcase

    st    = AW'(step);
    sum_x = px + st;
    sum_y = py + st;

`ifdef SPRITE_WRAP_EN
    if (dir_right)     x_nxt = (sum_x > X_MAX) ? 10'(sum_x - X_MOD) : 10'(sum_x);
    else if (dir_left) x_nxt = (px < st) ? 10'(px + X_MOD - st) : 10'(px - st);
    if (dir_down)      y_nxt = (sum_y > Y_MAX) ? 9'(sum_y - Y_MOD) : 9'(sum_y);
    else if (dir_up)   y_nxt = (py < st) ? 9'(py + Y_MOD - st) : 9'(py - st);
`else
    if (dir_right)     x_nxt = (sum_x > X_MAX) ? 10'(X_MAX) : 10'(sum_x);
    else if (dir_left) x_nxt = (px < st) ? 10'(0) : 10'(px - st);
    if (dir_down)      y_nxt = (sum_y > Y_MAX) ? 9'(Y_MAX) : 9'(sum_y);
    else if (dir_up)   y_nxt = (py < st) ? 9'(0) : 9'(py - st);
`endif
  end

  // State, synchronizers and registered outputs; only events change position
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      speed      <= SPD_W'(1);
      cnt        <= '0;
      btn_meta   <= '0;
      btn_sync   <= '0;
      match_d    <= 1'b0;
      frame_tick <= 1'b0;
      moving     <= 1'b0;
      sprite_x   <= 10'(INIT_X);
      sprite_y   <= 9'(INIT_Y);
    end else begin
      btn_meta   <= {btn_up, btn_down, btn_left, btn_right};
      btn_sync   <= btn_meta;
      match_d    <= match;
      frame_tick <= event_c;
      if (event_c) begin
        state    <= state_nxt;
        speed    <= speed_nxt;
        cnt      <= cnt_nxt;
        moving   <= any_dir;
        sprite_x <= x_nxt;
        sprite_y <= y_nxt;
      end
    end
  end

endmodule
